regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the single register-file write port (wen/waddr/wdata) between NREQ writeback
//  requesters, e.g. ALU result, load return and debug/init poke.
//  - Round-robin arbitration, one grant per cycle.
//  - valid/ready handshake per requester.
//  - Registered write-port outputs, driven straight into the register file's write port.
//  - Stall input freezes all grants.
//  - Start-up hold of INIT_CYC cycles after reset.
// PARAMETERS
//  NREQ      3    number of write requesters (2..8)
//  ASIZE     4    register address width
//  DSIZE     16   register data width
//  INIT_CYC  2    cycles after rst deasserts before the first grant (0 = none)
// PORTS
//  clk         in   1           clock, all state on rising edge
//  rst         in   1           synchronous, active-high reset
//  stall       in   1           1 = issue no grant this cycle
//  req_valid   in   NREQ        requester i has a write pending
//  req_addr    in   NREQ*ASIZE  requester i dest addr, bits [i*ASIZE +: ASIZE]
//  req_data    in   NREQ*DSIZE  requester i write data, bits [i*DSIZE +: DSIZE]
//  req_ready   out  NREQ        one-hot/zero; bit i = requester i accepted this cycle
//  wen         out  1           register-file write enable (registered)
//  waddr       out  ASIZE       register-file write address (registered)
//  wdata       out  DSIZE       register-file write data (registered)
//  busy        out  1           1 while in INIT state
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//  - state=INIT; init counter=0; rr pointer=0.
//  - Outputs wen=0, waddr=0, wdata=0.
//  - busy=1, req_ready=0 while rst=1.
//  FSM, two states:
//  - INIT: counter increments each cycle; req_ready=0, wen=0.
//    Move to RUN when counter==INIT_CYC-1. If INIT_CYC=0, reset goes straight to RUN.
//  - RUN: busy=0 and arbitration is active. Stays in RUN until rst.
//  Arbitration (combinational, RUN and stall=0):
//  - Search from index ptr upward, wrapping at NREQ-1 -> 0.
//  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
//  - No valid request, or stall=1, or INIT -> req_ready=0.
//  Handshake:
//  - A transfer happens when req_valid[i] & req_ready[i] at a posedge.
//  - The requester must hold valid, addr and data stable until that transfer.
//  - req_ready never depends on req_addr or req_data.
//  Pointer:
//  - On a transfer from index g, ptr <= (g==NREQ-1) ? 0 : g+1.
//  - Otherwise ptr holds.
//  - Any continuously-valid requester is served within NREQ granted cycles.
//  Output (latency 1):
//  - On a transfer, the next cycle drives wen=1, waddr=req_addr[g], wdata=req_data[g].
//  - With no transfer, wen=0 and waddr/wdata hold their last values.
//  - Back-to-back transfers give wen=1 on consecutive cycles.
//  Simultaneous/boundary cases:
//  - Two requesters targeting the same address are written in grant order; the later
//    grant wins. No merging.
//  - stall rising mid-stream: the write already registered still issues; no new grant.
//  - rst mid-operation: any pending registered write is dropped (wen=0 the next cycle).
//    Requesters must re-present after INIT.
//  - All requesters valid continuously: grants rotate 0,1,..,NREQ-1,0,...
// TESTING
//  1 Reset then INIT_CYC=2, all valid -> req_ready=0, busy=1 for 2 cycles after rst drops;
//    the cycle after busy falls, req_ready=001.
//  2 Only req1 valid, addr=4, data=16'h4890 -> ready=010 same cycle;
//    next cycle wen=1, waddr=4, wdata=16'h4890; the following cycle wen=0.
//  3 All 3 valid and held for 6 cycles -> ready sequence 001,010,100,001,010,100;
//    wen=1 on every cycle from the 2nd onward.
//  4 All valid, stall=1 for cycles 3-4 -> ready=000 in cycles 3-4;
//    the rotation resumes at the held-off index; wen=0 exactly one cycle after each stalled cycle.
//  5 req0 and req2 both addr=7, data 16'h0003 / 16'h8ff9, ptr=0 -> writes issue in order
//    16'h0003 then 16'h8ff9.
//  6 rst asserted the cycle after a grant -> wen=0 the next cycle, and no write ever issues
//    for that grant.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port between NREQ writeback requesters.
// Latency: grant is combinational in the request cycle; wen/waddr/wdata follow one cycle later.
// Backpressure: stall, reset or the INIT hold withhold every req_ready; requesters hold until granted.
module regfile_wr_arbiter #(
    parameter int NREQ     = 3,
    parameter int ASIZE    = 4,
    parameter int DSIZE    = 16,
    parameter int INIT_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ASIZE-1:0]  req_addr,
    input  logic [NREQ*DSIZE-1:0]  req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   wen,
    output logic [ASIZE-1:0]       waddr,
    output logic [DSIZE-1:0]       wdata,
    output logic                   busy
);

    // Pointer width covers indices 0..NREQ-1; counter width covers 0..INIT_CYC.
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (INIT_CYC > 0) ? $clog2(INIT_CYC + 1) : 1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // With no start-up hold, reset lands directly in RUN.
    localparam logic [0:0] ST_RESET = (INIT_CYC == 0) ? ST_RUN : ST_INIT;

    logic [0:0]       state;
    logic [CW-1:0]    init_cnt;
    logic [PW-1:0]    ptr;

    logic             arb_en;
    logic             grant_any;
    logic [PW-1:0]    grant_idx;
    logic [NREQ-1:0]  grant_oh;
    logic [ASIZE-1:0] sel_addr;
    logic [DSIZE-1:0] sel_data;

    logic             wen_q;
    logic [ASIZE-1:0] waddr_q;
    logic [DSIZE-1:0] wdata_q;

    // Index reached by stepping 'off' places up from 'base', wrapping at NREQ-1 -> 0.
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return PW'(s);
    endfunction

    // Grants are only offered in RUN, outside reset and while not stalled.
    assign arb_en = (state == ST_RUN) && !rst && !stall;

    // Round-robin search: first valid requester at or above ptr, wrapping; depends only on valid bits.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (arb_en && !grant_any && req_valid[wrap_idx(ptr, k)]) begin
                grant_any = 1'b1;
                grant_idx = wrap_idx(ptr, k);
            end
        end
    end

    // One-hot ready vector from the winning index; all zero when nobody wins.
    always_comb begin
        grant_oh = '0;
        if (grant_any) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign req_ready = grant_oh;

    // Address and data of the winner, captured into the write-port registers on transfer.
    assign sel_addr = req_addr[grant_idx*ASIZE +: ASIZE];
    assign sel_data = req_data[grant_idx*DSIZE +: DSIZE];

    // Start-up FSM: count INIT_CYC cycles in INIT, then stay in RUN until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RESET;
            init_cnt <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (int'(init_cnt) == INIT_CYC - 1) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Round-robin pointer moves just past the index that transferred, else holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_any) begin
            if (int'(grant_idx) == NREQ - 1) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end

    // Write-port registers: pulse wen for one cycle per transfer; addr/data hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wen_q <= grant_any;
            if (grant_any) begin
                waddr_q <= sel_addr;
                wdata_q <= sel_data;
            end
        end
    end

    // A write registered just before reset is squashed while rst is high so it never reaches the file.
    assign wen   = wen_q & ~rst;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

    assign busy  = rst || (state == ST_INIT);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomised and directed bench for regfile_wr_arbiter against a cycle-level reference model.
// The model tracks cycles since reset, a rotating priority index and the pending write.
// Directed sequences reproduce the documented scenarios; a random phase exercises the rest.
module tb_regfile_wr_arbiter;

    localparam int NREQ     = 3;
    localparam int ASIZE    = 4;
    localparam int DSIZE    = 16;
    localparam int INIT_CYC = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  stall;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*ASIZE-1:0] req_addr;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  wen;
    logic [ASIZE-1:0]      waddr;
    logic [DSIZE-1:0]      wdata;
    logic                  busy;

    regfile_wr_arbiter #(
        .NREQ(NREQ), .ASIZE(ASIZE), .DSIZE(DSIZE), .INIT_CYC(INIT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .wen(wen), .waddr(waddr), .wdata(wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int               since;
    int               rr;
    bit               pend;
    logic [ASIZE-1:0] m_addr;
    logic [DSIZE-1:0] m_data;

    // stimulus policy
    bit [NREQ-1:0] keep;
    bit            rnd_mode;

    // last observed outputs (sampled at negedge)
    logic [NREQ-1:0]  obs_ready;
    logic             obs_wen;
    logic [ASIZE-1:0] obs_waddr;
    logic [DSIZE-1:0] obs_wdata;
    logic             obs_busy;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic present(input int i);
        req_valid[i] = 1'b1;
        req_addr[i*ASIZE +: ASIZE] = ASIZE'($urandom);
        req_data[i*DSIZE +: DSIZE] = DSIZE'($urandom);
    endtask

    task automatic set_req(input int i, input logic [ASIZE-1:0] a, input logic [DSIZE-1:0] d);
        req_valid[i] = 1'b1;
        req_addr[i*ASIZE +: ASIZE] = a;
        req_data[i*DSIZE +: DSIZE] = d;
    endtask

    // One clock: compare against the model at negedge, advance the model, refill requesters.
    task automatic cycle();
        int  g;
        bit  run;
        logic [NREQ-1:0] exp_ready;
        @(negedge clk);
        obs_ready = req_ready;
        obs_wen   = wen;
        obs_waddr = waddr;
        obs_wdata = wdata;
        obs_busy  = busy;

        run = !rst && (since >= INIT_CYC);
        g = -1;
        if (run && !stall) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && req_valid[(rr + k) % NREQ]) g = (rr + k) % NREQ;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;

        check_val("ready", 32'(req_ready), 32'(exp_ready));
        check_val("busy",  32'(busy),      32'(!run));
        check_val("wen",   32'(wen),       32'(pend && !rst));
        check_val("waddr", 32'(waddr),     32'(m_addr));
        check_val("wdata", 32'(wdata),     32'(m_data));

        if (rst) begin
            since = 0; rr = 0; pend = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            if (since < INIT_CYC) since++;
            if (g >= 0) begin
                pend   = 1'b1;
                m_addr = req_addr[g*ASIZE +: ASIZE];
                m_data = req_data[g*DSIZE +: DSIZE];
                rr     = (g + 1) % NREQ;
            end else begin
                pend = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        if (g >= 0) begin
            if (keep[g]) present(g);
            else req_valid[g] = 1'b0;
        end
        if (rnd_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) present(i);
            end
            keep  = NREQ'($urandom);
            stall = ($urandom_range(0, 5) == 0);
            rst   = ($urandom_range(0, 150) == 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; req_valid = '0; keep = '0;
        repeat (2) cycle();
        rst = 1'b0;
        repeat (INIT_CYC) cycle();
    endtask

    logic [NREQ-1:0] stall_ready [6];
    logic            stall_wen   [6];

    initial begin
        rnd_mode = 1'b0;
        since = 0; rr = 0; pend = 1'b0; m_addr = '0; m_data = '0;
        rst = 1'b1; stall = 1'b0; req_valid = '0; req_addr = '0; req_data = '0; keep = '0;
        repeat (3) cycle();
        check_val("rst_busy", 32'(obs_busy), 32'd1);
        check_val("rst_wen",  32'(obs_wen),  32'd0);

        // 1: start-up hold with all requesters valid
        rst = 1'b0; keep = '1;
        for (int i = 0; i < NREQ; i++) present(i);
        for (int c = 0; c < INIT_CYC; c++) begin
            cycle();
            check_val("init_ready", 32'(obs_ready), 32'd0);
            check_val("init_busy",  32'(obs_busy),  32'd1);
        end
        // 3: continuous rotation starting from index 0
        for (int c = 0; c < 6; c++) begin
            cycle();
            check_val("rot_busy",  32'(obs_busy),  32'd0);
            check_val("rot_ready", 32'(obs_ready), 32'(1 << (c % NREQ)));
            if (c > 0) check_val("rot_wen", 32'(obs_wen), 32'd1);
        end

        // 4: stall for cycles 3-4 of a continuous stream
        stall_ready[0] = 3'b001; stall_ready[1] = 3'b010; stall_ready[2] = 3'b000;
        stall_ready[3] = 3'b000; stall_ready[4] = 3'b100; stall_ready[5] = 3'b001;
        stall_wen[0] = 1'b1; stall_wen[1] = 1'b1; stall_wen[2] = 1'b1;
        stall_wen[3] = 1'b0; stall_wen[4] = 1'b0; stall_wen[5] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            stall = (c == 2 || c == 3);
            cycle();
            check_val("stall_ready", 32'(obs_ready), 32'(stall_ready[c]));
            check_val("stall_wen",   32'(obs_wen),   32'(stall_wen[c]));
        end
        stall = 1'b0;

        // 2: single requester, single write
        do_reset();
        set_req(1, 4'd4, 16'h4890);
        cycle();
        check_val("single_ready", 32'(obs_ready), 32'b010);
        cycle();
        check_val("single_wen",   32'(obs_wen),   32'd1);
        check_val("single_waddr", 32'(obs_waddr), 32'd4);
        check_val("single_wdata", 32'(obs_wdata), 32'h4890);
        cycle();
        check_val("single_wen_off", 32'(obs_wen), 32'd0);

        // 5: same destination from two requesters, written in grant order
        do_reset();
        set_req(0, 4'd7, 16'h0003);
        set_req(2, 4'd7, 16'h8ff9);
        cycle();
        check_val("same_ready0", 32'(obs_ready), 32'b001);
        cycle();
        check_val("same_ready2", 32'(obs_ready), 32'b100);
        check_val("same_wdata0", 32'(obs_wdata), 32'h0003);
        cycle();
        check_val("same_wen",    32'(obs_wen),   32'd1);
        check_val("same_waddr",  32'(obs_waddr), 32'd7);
        check_val("same_wdata1", 32'(obs_wdata), 32'h8ff9);

        // 6: reset right after a grant drops the pending write
        do_reset();
        set_req(0, 4'd9, 16'hbeef);
        cycle();
        check_val("drop_ready", 32'(obs_ready), 32'b001);
        rst = 1'b1;
        cycle();
        check_val("drop_wen_rst", 32'(obs_wen), 32'd0);
        cycle();
        check_val("drop_wen_next", 32'(obs_wen), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < INIT_CYC + 2; c++) begin
            cycle();
            check_val("drop_wen_after", 32'(obs_wen), 32'd0);
        end

        // random phase
        rnd_mode = 1'b1;
        repeat (3000) cycle();
        rnd_mode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
